// File: rtl/audio_tone_player.sv
// ============================================================================
//  Module      : audio_tone_player
//  Description : Square-wave note player; plays one tone of programmable pitch
//                and duration, then pulses done. Optional post-note silent gap
//                is built when the AUDIO_GAP_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_tone_player #(
    parameter int PRESCALE    = 100,
    parameter int UNIT_CYCLES = 1_200_000,
`ifdef AUDIO_GAP_EN
    parameter int GAP_CYCLES  = 240_000,
`endif
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audioreg,
    input  logic       audioact,
    input  logic [7:0] data_in,
    output logic       speaker,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] c_prescale = CNT_W'(PRESCALE);
    localparam logic [CNT_W-1:0] c_unit     = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
`ifdef AUDIO_GAP_EN
    localparam logic [CNT_W-1:0] c_gap      = CNT_W'(GAP_CYCLES);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
`ifdef AUDIO_GAP_EN
        S_GAP  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_tone, r_dur;
    logic [CNT_W-1:0] r_phase, w_phase_nxt;
    logic [CNT_W-1:0] r_dur_cnt, w_dur_cnt_nxt;
    logic             r_speaker, w_speaker_nxt;
    logic             r_busy, r_done;
    logic [CNT_W-1:0] w_half, w_dur_len;
`ifdef AUDIO_GAP_EN
    logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
`endif

    assign w_half    = CNT_W'(r_tone) * c_prescale;
    assign w_dur_len = CNT_W'(r_dur) * c_unit;

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_dur_cnt_nxt = r_dur_cnt;
        w_speaker_nxt = r_speaker;
`ifdef AUDIO_GAP_EN
        w_gap_cnt_nxt = r_gap_cnt;
`endif
        case (r_state)
            S_PLAY: begin
                if (r_dur_cnt >= w_dur_len - c_one) begin
                    w_phase_nxt   = '0;
                    w_dur_cnt_nxt = '0;
                    w_speaker_nxt = 1'b0;
`ifdef AUDIO_GAP_EN
                    w_state_nxt   = S_GAP;
`else
                    w_state_nxt   = S_DONE;
`endif
                end else begin
                    w_dur_cnt_nxt = r_dur_cnt + c_one;
                    // >= rather than == so a pitch lowered mid-note still wraps
                    if (w_half == '0) begin
                        w_speaker_nxt = 1'b0;
                        w_phase_nxt   = '0;
                    end else if (r_phase >= w_half - c_one) begin
                        w_speaker_nxt = ~r_speaker;
                        w_phase_nxt   = '0;
                    end else begin
                        w_phase_nxt   = r_phase + c_one;
                    end
                end
            end
`ifdef AUDIO_GAP_EN
            S_GAP: begin
                if (r_gap_cnt >= c_gap - c_one) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_one;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // A new play command overrides whatever note is in progress
        if (audioact) begin
            w_state_nxt   = (data_in == 8'd0) ? S_DONE : S_PLAY;
            w_phase_nxt   = '0;
            w_dur_cnt_nxt = '0;
            w_speaker_nxt = 1'b0;
`ifdef AUDIO_GAP_EN
            w_gap_cnt_nxt = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tone    <= 8'd0;
            r_dur     <= 8'd0;
            r_phase   <= '0;
            r_dur_cnt <= '0;
            r_speaker <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef AUDIO_GAP_EN
            r_gap_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_dur_cnt <= w_dur_cnt_nxt;
            r_speaker <= w_speaker_nxt;
`ifdef AUDIO_GAP_EN
            r_busy    <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_GAP);
            r_gap_cnt <= w_gap_cnt_nxt;
`else
            r_busy    <= (w_state_nxt == S_PLAY);
`endif
            r_done    <= (w_state_nxt == S_DONE);
            if (audioreg) r_tone <= data_in;
            if (audioact) r_dur  <= data_in;
        end
    end

    assign speaker = r_speaker;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_audio_tone_player.sv
// ============================================================================
//  Module      : tb_audio_tone_player
//  Description : Scoreboard bench for audio_tone_player with directed notes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_tone_player;

    localparam int UNIT = 20;
`ifdef AUDIO_GAP_EN
    localparam int GAP = 5;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       audioreg = 1'b0;
    logic       audioact = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       speaker, busy, done;

    audio_tone_player #(
        .PRESCALE    (2),
        .UNIT_CYCLES (UNIT),
`ifdef AUDIO_GAP_EN
        .GAP_CYCLES  (GAP),
`endif
        .CNT_W       (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .audioreg (audioreg),
        .audioact (audioact),
        .data_in  (data_in),
        .speaker  (speaker),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int busy_len;
        int play_len;
        int n_tog;
        int first;
        int per;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: measures each note and scores it against the queue on done
    int   cyc = 0, act_cyc = 0, b_len = 0, n_tog = 0, first = -1, last = 0;
    int   int_bad = 0, spk_bad = 0, pl;
    logic prev_spk = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            b_len = 0; n_tog = 0; first = -1; int_bad = 0; spk_bad = 0;
        end else begin
            if (busy) begin
                pl = (q.size() > 0) ? q[0].play_len : 0;
                if (b_len < pl) begin
                    if (speaker != prev_spk) begin
                        if (first < 0) first = b_len;
                        else if (b_len - last != q[0].per) int_bad++;
                        last = b_len;
                        n_tog++;
                    end
                end else if (speaker) begin
                    spk_bad++;
                end
                b_len++;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("busy_len", b_len, e.busy_len);
                    chk("done_latency", cyc - act_cyc, e.busy_len + 1);
                    chk("toggle_count", n_tog, e.n_tog);
                    chk("first_toggle", first, e.first);
                    chk("period_errors", int_bad, 0);
                    chk("speaker_after_play", spk_bad, 0);
                    chk("speaker_at_done", int'(speaker), 0);
                end
            end
            if (audioact) begin
                act_cyc = cyc; b_len = 0; n_tog = 0; first = -1; last = 0;
                int_bad = 0; spk_bad = 0;
            end
        end
        prev_spk = (audioact && !reset) ? 1'b0 : speaker;
    end

    task automatic issue(input logic r, input logic a, input logic [7:0] d);
        @(posedge clk); #1;
        audioreg = r; audioact = a; data_in = d;
        @(posedge clk); #1;
        audioreg = 1'b0; audioact = 1'b0; data_in = 8'd0;
    endtask

    task automatic push(input int dur, input int n, input int f, input int per);
        exp_t x;
        x.play_len = dur * UNIT;
        x.busy_len = (dur == 0) ? 0 : dur * UNIT + GAP;
        x.n_tog    = n;
        x.first    = f;
        x.per      = per;
        q.push_back(x);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || busy) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 400) chk("drain_timeout", k, 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_speaker", int'(speaker), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;

        // tone_reg cleared by reset: full-length silent note
        push(1, 0, -1, 0);
        issue(1'b0, 1'b1, 8'h01);
        drain();

        // tone 3 -> half period 6, dur 2 -> 40 cycles
        issue(1'b1, 1'b0, 8'h03);
        push(2, 6, 6, 6);
        issue(1'b0, 1'b1, 8'h02);
        drain();

        // rest note
        issue(1'b1, 1'b0, 8'h00);
        push(1, 0, -1, 0);
        issue(1'b0, 1'b1, 8'h01);
        drain();

        // zero duration: done next cycle, no busy
        push(0, 0, -1, 0);
        issue(1'b0, 1'b1, 8'h00);
        drain();

        // reset mid-note aborts without done
        issue(1'b1, 1'b0, 8'h03);
        issue(1'b0, 1'b1, 8'h02);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_speaker", int'(speaker), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("abort_no_busy", int'(busy), 0);
        issue(1'b1, 1'b0, 8'h03);
        push(2, 6, 6, 6);
        issue(1'b0, 1'b1, 8'h02);
        drain();

        // both strobes together: tone 2 (half period 4), dur 2
        push(2, 9, 4, 4);
        issue(1'b1, 1'b1, 8'h02);
        drain();

        // restart mid-note: only the restarted note completes
        issue(1'b1, 1'b0, 8'h03);
        push(2, 6, 6, 6);
        issue(1'b0, 1'b1, 8'h02);
        repeat (30) @(posedge clk);
        issue(1'b0, 1'b1, 8'h02);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
